// File: rtl/bot_upd_bridge_pkg.sv
// bot_bridge_pkg: shared types for the rojobot/CPU update bridge.
//   state_e   : capture FSM encoding (IDLE, SETTLE, CAPTURE)
//   bot_bus_t : 32-bit bot register bus, fields LOCX 31:24, LOCY 23:16, SENS 15:8, INFO 7:0
//   MOT_STOP  : motor command that halts the bot
package bot_bridge_pkg;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_e;

    typedef struct packed {
        logic [7:0] locx;
        logic [7:0] locy;
        logic [7:0] sens;
        logic [7:0] info;
    } bot_bus_t;

    localparam logic [7:0] MOT_STOP = 8'h00;

endpackage

// File: rtl/bot_upd_bridge_sync.sv
// sync_edge_det: multi-flop synchroniser with a rising-edge pulse on its last stage.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous level input
//   rise_o : one-cycle pulse when the synchronised level goes 0->1
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic                                       last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            last_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/bot_upd_bridge.sv
// bot_upd_bridge: rojobot -> CPU update bridge with sticky flag, overrun counter and motor watchdog.
//   SI_ClkIn       : CPU clock, the only clock in the block
//   SI_Reset_N     : asynchronous active-low reset
//   upd_sysregs_in : rojobot update strobe (asynchronous)
//   bot_info_in    : rojobot register bus (asynchronous, stable between updates)
//   int_ack        : CPU acknowledge level
//   motctl_cpu     : CPU motor command
//   port_botinfo   : registered bus snapshot
//   port_botupdt   : sticky update-pending flag
//   motctl_bot     : registered motor command to the rojobot
//   missed_cnt     : saturating count of overrun updates
//   wdog_trip      : high while the watchdog forces the motor to stop
module bot_upd_bridge
    import bot_bridge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int WDOG_LIMIT    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             SI_ClkIn,
    input  logic             SI_Reset_N,
    input  logic             upd_sysregs_in,
    input  logic [31:0]      bot_info_in,
    input  logic             int_ack,
    input  logic [7:0]       motctl_cpu,
    output logic [31:0]      port_botinfo,
    output logic             port_botupdt,
    output logic [7:0]       motctl_bot,
    output logic [CNT_W-1:0] missed_cnt,
    output logic             wdog_trip
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW = $clog2(WDOG_LIMIT + 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]    CONSEC_MAX  = CW'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] MISSED_MAX  = '1;

    state_e           state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    bot_bus_t         info_q, info_d;
    logic             flag_q, flag_d;
    logic [CNT_W-1:0] missed_q, missed_d;
    logic [CW-1:0]    consec_q, consec_d;
    logic             trip_q, trip_d;
    logic [7:0]       mot_q, mot_d;
    logic             rise, capture, overrun;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (SI_ClkIn),
        .rst_ni (SI_Reset_N),
        .d_i    (upd_sysregs_in),
        .rise_o (rise)
    );

    // The snapshot is written on the edge that enters CAPTURE, so the flag and
    // data are already visible while the FSM sits in CAPTURE for its one cycle.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d  = rise ? SETTLE : IDLE;
                settle_d = rise ? SETTLE_LOAD : settle_q;
            end
            SETTLE: begin
                capture  = (settle_q == '0);
                state_d  = capture ? CAPTURE : SETTLE;
                settle_d = capture ? settle_q : settle_q - 1'b1;
            end
            CAPTURE: begin
                state_d  = rise ? SETTLE : IDLE;
                settle_d = rise ? SETTLE_LOAD : settle_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // A coincident ack counts as clearing the old flag, so it never overruns.
    always_comb begin
        overrun  = capture & flag_q & ~int_ack;
        info_d   = capture ? bot_bus_t'(bot_info_in) : info_q;
        flag_d   = capture | (flag_q & ~int_ack);
        missed_d = (overrun && missed_q != MISSED_MAX) ? missed_q + 1'b1 : missed_q;
        consec_d = (int_ack && flag_q) ? '0 :
                   (overrun && consec_q != CONSEC_MAX) ? consec_q + 1'b1 : consec_q;
        trip_d   = (consec_d == CONSEC_MAX);
        mot_d    = trip_d ? MOT_STOP : motctl_cpu;
    end

    always_ff @(posedge SI_ClkIn or negedge SI_Reset_N) begin
        if (!SI_Reset_N) begin
            state_q  <= IDLE;
            settle_q <= '0;
            info_q   <= '0;
            flag_q   <= 1'b0;
            missed_q <= '0;
            consec_q <= '0;
            trip_q   <= 1'b0;
            mot_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            info_q   <= info_d;
            flag_q   <= flag_d;
            missed_q <= missed_d;
            consec_q <= consec_d;
            trip_q   <= trip_d;
            mot_q    <= mot_d;
        end
    end

    assign port_botinfo = info_q;
    assign port_botupdt = flag_q;
    assign missed_cnt   = missed_q;
    assign wdog_trip    = trip_q;
    assign motctl_bot   = mot_q;

endmodule
